a2d_seq: RTL and testbench

A2D_SEQ -- requirements
Module: a2d_seq

---
 rtl/a2d_seq.sv | 147 ++++++++++++++
 tb/tb_a2d_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_seq.sv
`default_nettype none
// ============================================================================
// Module   : a2d_seq
// Brief    : Round-robin A2D sequencer (left, right, battery) over a shared
//            SPI master, two transactions per channel, with timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module a2d_seq #(
    parameter logic [2:0] LFT_CH  = 3'd0,
    parameter logic [2:0] RGHT_CH = 3'd4,
    parameter logic [2:0] BATT_CH = 3'd5,
    parameter logic [9:0] TMO     = 10'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        busy,
    output logic        rnd_done,
    output logic        tmo_err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CMD   = 3'd1;
    localparam logic [2:0] WAIT1 = 3'd2;
    localparam logic [2:0] RD    = 3'd3;
    localparam logic [2:0] WAIT2 = 3'd4;

    localparam logic [1:0] c_IDX_LFT  = 2'd0;
    localparam logic [1:0] c_IDX_RGHT = 2'd1;
    localparam logic [1:0] c_IDX_BATT = 2'd2;

    // Abort on the edge where the counter would reach TMO-1, so tmo_err
    // lands exactly TMO cycles after the strobe that opened the wait.
    localparam logic [9:0] c_TMO_LAST = TMO - 10'd2;

    logic [2:0]  r_state;
    logic [1:0]  r_idx;
    logic [9:0]  r_cnt;
    logic [15:0] r_cmd;
    logic [11:0] r_lft;
    logic [11:0] r_rght;
    logic [11:0] r_batt;
    logic        r_rnd_done;
    logic        r_tmo_err;

    logic [2:0]  w_nxt_ch;
    logic        w_tmo_hit;
    logic        w_unused_rd_hi;

    assign w_unused_rd_hi = ^spi_rd_data[15:12];
    assign w_tmo_hit      = (r_cnt == c_TMO_LAST);

    // Channel number of the channel following the current one.
    always_comb begin
        w_nxt_ch = RGHT_CH;
        if (r_idx == c_IDX_RGHT) begin
            w_nxt_ch = BATT_CH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= c_IDX_LFT;
            r_cnt      <= 10'd0;
            r_cmd      <= 16'h0000;
            r_lft      <= 12'h000;
            r_rght     <= 12'h000;
            r_batt     <= 12'h000;
            r_rnd_done <= 1'b0;
            r_tmo_err  <= 1'b0;
        end else begin
            r_rnd_done <= 1'b0;
            r_tmo_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (nxt) begin
                        r_state <= CMD;
                        r_idx   <= c_IDX_LFT;
                        r_cmd   <= {2'b00, LFT_CH, 11'h000};
                    end
                end
                CMD: begin
                    r_state <= WAIT1;
                    r_cnt   <= 10'd0;
                end
                WAIT1: begin
                    if (spi_done) begin
                        r_state <= RD;
                    end else if (w_tmo_hit) begin
                        r_state   <= IDLE;
                        r_tmo_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                RD: begin
                    r_state <= WAIT2;
                    r_cnt   <= 10'd0;
                end
                WAIT2: begin
                    if (spi_done) begin
                        case (r_idx)
                            c_IDX_LFT:  r_lft  <= spi_rd_data[11:0];
                            c_IDX_RGHT: r_rght <= spi_rd_data[11:0];
                            default:    r_batt <= spi_rd_data[11:0];
                        endcase
                        if (r_idx == c_IDX_BATT) begin
                            r_state    <= IDLE;
                            r_rnd_done <= 1'b1;
                        end else begin
                            r_state <= CMD;
                            r_idx   <= r_idx + 2'd1;
                            r_cmd   <= {2'b00, w_nxt_ch, 11'h000};
                        end
                    end else if (w_tmo_hit) begin
                        r_state   <= IDLE;
                        r_tmo_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign spi_wrt  = (r_state == CMD) || (r_state == RD);
    assign busy     = (r_state != IDLE);
    assign spi_cmd  = r_cmd;
    assign lft_ld   = r_lft;
    assign rght_ld  = r_rght;
    assign batt     = r_batt;
    assign rnd_done = r_rnd_done;
    assign tmo_err  = r_tmo_err;

endmodule
`default_nettype wire

// File: tb/tb_a2d_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_a2d_seq
// Brief    : Self-checking bench for a2d_seq with an SPI responder model and
//            a command scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_a2d_seq;

    localparam logic [9:0] TMO = 10'd1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        nxt;
    logic        spi_done;
    logic [15:0] spi_rd_data;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] batt;
    logic        busy;
    logic        rnd_done;
    logic        tmo_err;

    a2d_seq #(
        .LFT_CH (3'd0),
        .RGHT_CH(3'd4),
        .BATT_CH(3'd5),
        .TMO    (TMO)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .nxt        (nxt),
        .spi_done   (spi_done),
        .spi_rd_data(spi_rd_data),
        .spi_wrt    (spi_wrt),
        .spi_cmd    (spi_cmd),
        .lft_ld     (lft_ld),
        .rght_ld    (rght_ld),
        .batt       (batt),
        .busy       (busy),
        .rnd_done   (rnd_done),
        .tmo_err    (tmo_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rd_l;
        logic [15:0] rd_r;
        logic [15:0] rd_b;
        logic [11:0] ex_l;
        logic [11:0] ex_r;
        logic [11:0] ex_b;
        bit          extra_nxt;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int wrt_cnt = 0;
    int rnd_cnt = 0;
    int tmo_cnt = 0;
    int tx_in_rnd = 0;
    int withhold_tx = -1;
    int rd_wrt_cyc = 0;
    bit stray_req = 1'b0;
    logic [15:0] cmd_q[$];
    logic [15:0] rd_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: score every strobe against the expected command queue.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (spi_wrt === 1'b1) begin
                wrt_cnt++;
                if (cmd_q.size() == 0) begin
                    check("unexpected_spi_wrt", 32'(spi_cmd), 32'hFFFF_FFFF);
                end else begin
                    check("spi_cmd", 32'(spi_cmd), 32'(cmd_q.pop_front()));
                end
            end
            if (rnd_done === 1'b1) rnd_cnt++;
            if (tmo_err === 1'b1) tmo_cnt++;
        end
    end

    // SPI responder: spi_done 20 cycles after each strobe; odd strobes are reads.
    initial begin
        int cd;
        bit phase;
        logic [15:0] pend;
        cd = 0;
        phase = 1'b0;
        pend = 16'h0000;
        spi_done = 1'b0;
        spi_rd_data = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            spi_done = 1'b0;
            if (rst) begin
                cd = 0;
                phase = 1'b0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        spi_done = 1'b1;
                        spi_rd_data = pend;
                    end
                end
                if (stray_req) begin
                    spi_done = 1'b1;
                    spi_rd_data = 16'h0777;
                    stray_req = 1'b0;
                end
                if (spi_wrt === 1'b1) begin
                    if (phase) pend = (rd_q.size() > 0) ? rd_q.pop_front() : 16'hBAD0;
                    else       pend = 16'hDEAD;
                    if (tx_in_rnd == withhold_tx) begin
                        cd = 0;
                        rd_wrt_cyc = cyc;
                    end else begin
                        cd = 20;
                    end
                    phase = ~phase;
                    tx_in_rnd++;
                end
            end
        end
    end

    task automatic start_round(input int ncmd, input logic [15:0] d0, d1, d2);
        logic [15:0] cmds[6];
        cmds = '{16'h0000, 16'h0000, 16'h2000, 16'h2000, 16'h2800, 16'h2800};
        for (int i = 0; i < ncmd; i++) cmd_q.push_back(cmds[i]);
        rd_q.push_back(d0);
        rd_q.push_back(d1);
        rd_q.push_back(d2);
        tx_in_rnd = 0;
        wrt_cnt = 0;
        rnd_cnt = 0;
        tmo_cnt = 0;
        @(posedge clk);
        #1;
        check("busy_before_start", 32'(busy), 32'd0);
        nxt = 1'b1;
        @(posedge clk);
        #1;
        nxt = 1'b0;
        check("first_wrt_latency", 32'(spi_wrt), 32'd1);
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Returns 1 on rnd_done, 2 on tmo_err, 0 if the bound expires.
    task automatic wait_end(input bit extra, output int how, output int end_cyc);
        how = 0;
        end_cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            nxt = extra && (i == 5 || i == 30 || i == 60);
            if (rnd_done === 1'b1 || tmo_err === 1'b1) begin
                how = rnd_done ? 1 : 2;
                end_cyc = cyc;
                check("busy_low_at_pulse", 32'(busy), 32'd0);
                break;
            end
        end
        nxt = 1'b0;
        if (how == 0) check("round_end_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_results(input string tag, input logic [11:0] l, r, b);
        check({tag, "_lft_ld"}, 32'(lft_ld), 32'(l));
        check({tag, "_rght_ld"}, 32'(rght_ld), 32'(r));
        check({tag, "_batt"}, 32'(batt), 32'(b));
    endtask

    initial begin
        vec_t vecs[3];
        int how;
        int end_cyc;

        vecs[0] = '{16'h0ABC, 16'h0123, 16'h0FFF, 12'hABC, 12'h123, 12'hFFF, 1'b0};
        vecs[1] = '{16'hF555, 16'h8123, 16'hFAAA, 12'h555, 12'h123, 12'hAAA, 1'b0};
        vecs[2] = '{16'h0321, 16'h0654, 16'h0987, 12'h321, 12'h654, 12'h987, 1'b1};

        rst = 1'b1;
        nxt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_spi_wrt", 32'(spi_wrt), 32'd0);
        check("rst_spi_cmd", 32'(spi_cmd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", 32'({rnd_done, tmo_err}), 32'd0);
        check_results("rst", 12'h000, 12'h000, 12'h000);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 3; v++) begin
            start_round(6, vecs[v].rd_l, vecs[v].rd_r, vecs[v].rd_b);
            wait_end(vecs[v].extra_nxt, how, end_cyc);
            check("round_end_kind", 32'(how), 32'd1);
            repeat (3) @(posedge clk);
            #1;
            check("wrt_count", 32'(wrt_cnt), 32'd6);
            check("rnd_done_count", 32'(rnd_cnt), 32'd1);
            check("tmo_err_count", 32'(tmo_cnt), 32'd0);
            check("busy_idle", 32'(busy), 32'd0);
            check("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
            check_results("vec", vecs[v].ex_l, vecs[v].ex_r, vecs[v].ex_b);
        end

        // Timeout on the right-channel read (strobe index 3 in the round).
        withhold_tx = 3;
        start_round(4, 16'h0111, 16'h0222, 16'h0333);
        wait_end(1'b0, how, end_cyc);
        withhold_tx = -1;
        check("tmo_end_kind", 32'(how), 32'd2);
        check("tmo_latency", 32'(end_cyc - rd_wrt_cyc), 32'(TMO));
        repeat (3) @(posedge clk);
        #1;
        check("tmo_wrt_count", 32'(wrt_cnt), 32'd4);
        check("tmo_rnd_done_count", 32'(rnd_cnt), 32'd0);
        check("tmo_err_count", 32'(tmo_cnt), 32'd1);
        check("tmo_busy", 32'(busy), 32'd0);
        check_results("tmo", 12'h111, 12'h654, 12'h987);
        rd_q.delete();

        // Stray spi_done in IDLE.
        wrt_cnt = 0;
        stray_req = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("stray_busy", 32'(busy), 32'd0);
        check("stray_wrt_count", 32'(wrt_cnt), 32'd0);
        check_results("stray", 12'h111, 12'h654, 12'h987);

        // Reset in WAIT1 of the battery channel (after the 5th strobe).
        start_round(6, 16'h0AAA, 16'h0BBB, 16'h0CCC);
        for (int i = 0; i < 3000 && tx_in_rnd < 5; i++) begin
            @(posedge clk);
            #1;
        end
        check("reached_batt_cmd", 32'(tx_in_rnd), 32'd5);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_spi_wrt", 32'(spi_wrt), 32'd0);
        check("async_rst_spi_cmd", 32'(spi_cmd), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_pulses", 32'({rnd_done, tmo_err}), 32'd0);
        check_results("async_rst", 12'h000, 12'h000, 12'h000);
        cmd_q.delete();
        rd_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_no_pulses", 32'(rnd_cnt + tmo_cnt), 32'd0);
        repeat (2) @(posedge clk);

        start_round(6, vecs[0].rd_l, vecs[0].rd_r, vecs[0].rd_b);
        wait_end(1'b0, how, end_cyc);
        check("post_rst_end_kind", 32'(how), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_wrt_count", 32'(wrt_cnt), 32'd6);
        check("post_rst_rnd_done_count", 32'(rnd_cnt), 32'd1);
        check_results("post_rst", 12'hABC, 12'h123, 12'hFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
